// File: rtl/multip_nch_pipe.sv
// rtl/multip_nch_pipe.sv - NCH-channel sign-magnitude fractional multiplier pipeline
//
// Multiplies one unsigned factor iF by NCH sign-magnitude gains and returns,
// per channel, the top DW-1 bits of the product with the gain's sign. Negative
// zero is folded to +0. The pipeline is LAT stages deep, uses a valid/ready
// handshake, and stalls as a whole while the output is held.
//
// Optional build macro: MULTIP_NCH_ROUND_EN
//   undefined : magnitude is the truncated top of the product
//   defined   : round-half-up on the first discarded bit, saturating
//
// Ports:
//   iClk    in   1        clock, rising edge
//   iRst    in   1        synchronous active-high reset
//   iValid  in   1        input word valid
//   oReady  out  1        input accepted this cycle when iValid is high
//   iF      in   FW       unsigned common factor
//   iG      in   NCH*GW   sign-magnitude gains, channel c at [c*GW +: GW]
//   iReady  in   1        downstream takes oX this cycle
//   oValid  out  1        oX holds a result
//   oX      out  NCH*DW   sign-magnitude results, channel c at [c*DW +: DW]
//   oBusy   out  1        some pipeline stage holds a valid word

module multip_nch_pipe #(
    parameter int NCH = 2,
    parameter int FW  = 17,
    parameter int GW  = 17,
    parameter int DW  = 16,
    parameter int LAT = 3
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    output logic              oReady,
    input  logic [FW-1:0]     iF,
    input  logic [NCH*GW-1:0] iG,
    input  logic              iReady,
    output logic              oValid,
    output logic [NCH*DW-1:0] oX,
    output logic              oBusy
);

    localparam int PW = FW + GW - 1;

    // Product bits kept past stage 2: the magnitude field, plus the first
    // discarded bit when rounding is built in.
`ifdef MULTIP_NCH_ROUND_EN
    localparam int KW = DW;
`else
    localparam int KW = DW - 1;
`endif

    logic             stall;
    logic             adv;
    logic [LAT:1]     v_q;
    logic [LAT:1]     v_d;
    logic             busy_q;
    logic [FW-1:0]    f_q;
    logic [NCH*GW-1:0] g_q;
    logic [NCH*KW-1:0] top_c;
    logic [NCH-1:0]   sgn_c;
    logic [NCH*KW-1:0] fin_top;
    logic [NCH-1:0]   fin_sgn;

    // Top KW bits of the exact PW-bit product f*m.
    function automatic logic [KW-1:0] prod_top(input logic [FW-1:0] f,
                                               input logic [GW-2:0] m);
        return KW'(({{(PW-FW){1'b0}}, f} * {{FW{1'b0}}, m}) >> (PW - KW));
    endfunction

    // Final formatting: optional rounding, then -0 suppression.
    function automatic logic [DW-1:0] fmt_word(input logic [KW-1:0] t,
                                               input logic s);
        logic [DW-2:0] mag;
`ifdef MULTIP_NCH_ROUND_EN
        logic [DW-1:0] sum;
        sum = {1'b0, t[KW-1:1]} + {{(DW-1){1'b0}}, t[0]};
        mag = sum[DW-1] ? '1 : sum[DW-2:0];
`else
        mag = t;
`endif
        return {s & (mag != '0), mag};
    endfunction

    // Whole-pipe stall: nothing moves while a result waits for the consumer.
    assign stall  = v_q[LAT] & ~iReady;
    assign adv    = ~stall;
    assign oReady = ~stall;
    assign oValid = v_q[LAT];
    assign oBusy  = busy_q;

    always_comb begin
        v_d = v_q;
        if (adv) begin
            v_d[1] = iValid;
            for (int k = 2; k <= LAT; k++) begin
                v_d[k] = v_q[k-1];
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            v_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            busy_q <= |v_d;
        end
    end

    // Stage 1: operand registers, so iF/iG never reach oX combinationally.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            f_q <= '0;
            g_q <= '0;
        end else if (adv && iValid) begin
            f_q <= iF;
            g_q <= iG;
        end
    end

    always_comb begin
        top_c = '0;
        sgn_c = '0;
        for (int c = 0; c < NCH; c++) begin
            top_c[c*KW +: KW] = prod_top(f_q, g_q[c*GW +: GW-1]);
            sgn_c[c]          = g_q[c*GW + GW - 1];
        end
    end

    // Stages 2..LAT-1 register and delay the product; with LAT=2 the product
    // feeds the output stage directly.
    if (LAT > 2) begin : g_dly
        logic [NCH*KW-1:0] top_q [2:LAT-1];
        logic [NCH-1:0]    sgn_q [2:LAT-1];

        always_ff @(posedge iClk) begin
            if (iRst) begin
                for (int k = 2; k <= LAT - 1; k++) begin
                    top_q[k] <= '0;
                    sgn_q[k] <= '0;
                end
            end else if (adv) begin
                top_q[2] <= top_c;
                sgn_q[2] <= sgn_c;
                for (int k = 3; k <= LAT - 1; k++) begin
                    top_q[k] <= top_q[k-1];
                    sgn_q[k] <= sgn_q[k-1];
                end
            end
        end

        assign fin_top = top_q[LAT-1];
        assign fin_sgn = sgn_q[LAT-1];
    end else begin : g_nodly
        assign fin_top = top_c;
        assign fin_sgn = sgn_c;
    end

    // Stage LAT: formatted, registered output; held while stalled.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oX <= '0;
        end else if (adv) begin
            for (int c = 0; c < NCH; c++) begin
                oX[c*DW +: DW] <= fmt_word(fin_top[c*KW +: KW], fin_sgn[c]);
            end
        end
    end

endmodule
